// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the instruction-fetch requester and the data
// requester. Data wins by default; a starvation counter forces a fetch grant
// after MAX_STARVE consecutive data grants made while a fetch was waiting.
// A fetch flush lets the in-flight memory access finish but drops its response.
// Size encoding on d_size / mem_size: 0 = byte, 1 = halfword, 2 = word.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic            clk,
    input  logic            rstn,
    // instruction-fetch requester
    input  logic            i_req,
    input  logic [XLEN-1:0] i_adr,
    input  logic            i_flush,
    output logic [XLEN-1:0] i_q,
    output logic            i_ack,
    output logic            i_err,
    // data requester
    input  logic            d_req,
    input  logic [XLEN-1:0] d_adr,
    input  logic [XLEN-1:0] d_d,
    input  logic            d_we,
    input  logic [1:0]      d_size,
    output logic [XLEN-1:0] d_q,
    output logic            d_ack,
    output logic            d_err,
    // shared memory port
    output logic            mem_req,
    output logic [XLEN-1:0] mem_adr,
    output logic [XLEN-1:0] mem_d,
    output logic            mem_we,
    output logic [1:0]      mem_size,
    input  logic [XLEN-1:0] mem_q,
    input  logic            mem_ack,
    input  logic            mem_err
);

    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam int         CW        = $clog2(MAX_STARVE + 1);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(MAX_STARVE);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t        state;
    logic          discard;
    logic [CW-1:0] starve_cnt;

    logic fetch_ok;
    logic grant_d;
    logic grant_i;
    logic term;

    // Grant decision for the IDLE state: data first unless fetch has starved.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        fetch_ok = 1'b0;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        fetch_ok = i_req & ~i_flush;
        grant_d  = d_req & (~fetch_ok | (starve_cnt != STARVE_LIMIT));
        grant_i  = fetch_ok & ~grant_d;
    end

    assign term = mem_ack | mem_err;

    // Port FSM: grants in IDLE, holds the registered request until termination.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
        if (!rstn) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_adr  <= '0;
            mem_d    <= '0;
            mem_size <= SIZE_WORD;
            discard  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state    <= BUSY_D;
                        mem_req  <= 1'b1;
                        mem_adr  <= d_adr;
                        mem_d    <= d_d;
                        mem_we   <= d_we;
                        mem_size <= d_size;
                    end else if (grant_i) begin
                        // fetches are word reads; mem_d is left as it was
                        state    <= BUSY_I;
                        mem_req  <= 1'b1;
                        mem_adr  <= i_adr;
                        mem_we   <= 1'b0;
                        mem_size <= SIZE_WORD;
                    end
                end
                BUSY_I: begin
                    if (term) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        discard <= 1'b0;
                    end else if (i_flush) begin
                        discard <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (term) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: counts data grants that bypassed a waiting fetch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (!i_req) begin
            starve_cnt <= '0;
        end else if (state == IDLE && grant_i) begin
            starve_cnt <= '0;
        end else if (state == IDLE && grant_d && starve_cnt != STARVE_LIMIT) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Response routing: the current owner sees the termination; flushed fetches see nothing.
    assign d_ack = mem_ack & (state == BUSY_D);
    assign d_err = mem_err & (state == BUSY_D);
    assign i_ack = mem_ack & (state == BUSY_I) & ~discard & ~i_flush;
    assign i_err = mem_err & (state == BUSY_I) & ~discard & ~i_flush;
    assign i_q   = mem_q;
    assign d_q   = mem_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch requester and its data requester.
- Used in single-port memory configurations of the core.
- Data accesses have priority. A starvation counter guarantees fetch progress.
- Fetch flushes discard in-flight fetch responses without aborting the memory transaction.

Parameters:
XLEN, 32, address/data width
MAX_STARVE, 4, consecutive data grants allowed while a fetch is pending before fetch is forced to win (≥1)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
i_req  in  1  fetch request; held until i_ack/i_err or flush
i_adr  in  XLEN  fetch address
i_flush  in  1  fetch flush (branch/trap redirect)
i_q  out  XLEN  fetch read data (= mem_q)
i_ack  out  1  fetch transfer complete
i_err  out  1  fetch bus error
d_req  in  1  data request; held until d_ack/d_err
d_adr  in  XLEN  data address
d_d  in  XLEN  store data
d_we  in  1  store when 1
d_size  in  biu_size_t  access size
d_q  out  XLEN  load data (= mem_q)
d_ack  out  1  data transfer complete
d_err  out  1  data bus error
mem_req  out  1  memory request, registered
mem_adr  out  XLEN  registered address
mem_d  out  XLEN  registered write data
mem_we  out  1  registered write enable
mem_size  out  biu_size_t  registered size; WORD for fetches
mem_ack  in  1  memory complete
mem_err  in  1  memory error (terminates like ack)

Behaviour:
- Clock is clk. Reset is rstn: synchronous, active-low.
- Reset (rstn=0 at a rising edge):
  - state=IDLE; mem_req, mem_we, discard = 0; mem_adr, mem_d = 0; mem_size=WORD; starve_cnt=0.
  - Applies mid-transaction as well; the memory side must tolerate the dropped mem_req.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE grant decision, sampled each cycle:
  - Fetch eligible = i_req & ~i_flush.
  - Data only → BUSY_D. Fetch only → BUSY_I.
  - Both: BUSY_I if starve_cnt==MAX_STARVE, else BUSY_D.
  - On grant, latch the requester's adr/d/we/size into the mem_* registers and set mem_req=1.
  - mem_req rises the cycle after the request is first seen (1-cycle grant latency).
  - Fetch grants drive mem_we=0, mem_size=WORD, mem_d unchanged.
- BUSY_x: mem_* outputs hold stable until termination.
  - Termination = mem_ack | mem_err. Next state is IDLE and mem_req=0.
  - After a termination at cycle M, the earliest new mem_req is M+2 (one bubble cycle).
- Response routing (combinational):
  - d_ack = mem_ack & BUSY_D; d_err = mem_err & BUSY_D.
  - i_ack = mem_ack & BUSY_I & ~discard & ~i_flush; i_err likewise with mem_err.
  - i_q = d_q = mem_q always.
- Flush:
  - i_flush in BUSY_I sets discard. The transaction runs to completion, its response is suppressed, and discard clears on termination.
  - i_flush in IDLE blocks the fetch grant that cycle.
  - i_flush is ignored in BUSY_D.
- Starvation counter (saturating at MAX_STARVE, width $clog2(MAX_STARVE+1)):
  - Increments on each data grant made while i_req=1.
  - Clears on a fetch grant, or in any cycle with i_req=0.
- Requester rule: a req still high in the cycle after its ack is a new request.
- mem_ack/mem_err asserted in IDLE are ignored; no output pulses.
- mem_ack and mem_err together: treated as an error; both the ack and err outputs pulse to the owner.

Test Plan:
- Reset then d_req with d_adr=0x100, d_we=1, d_d=0xDEADBEEF, size=WORD → mem_req=1 next cycle with matching fields; mem_ack 3 cycles later → single-cycle d_ack; mem_req=0 the following cycle.
- i_req and d_req held continuously, memory acks in 1 cycle, MAX_STARVE=4 → grant sequence D,D,D,D,I,D,D,D,D,I; no fetch waits more than 4 data transactions.
- Fetch to 0x200 granted, i_flush pulsed 1 cycle before mem_ack → no i_ack; mem_req drops after ack; a new i_req to 0x240 is granted 2 cycles after that ack.
- Data load gets mem_err=1 with mem_q=0x0 → d_err=1, d_ack=0, state returns to IDLE; a pending fetch is granted next.
- rstn=0 during BUSY_D → mem_req=0 after the edge; a stray mem_ack afterwards produces no d_ack or i_ack; the next request grants normally.
